// File: rtl/cpu_pkg.sv
// Shared pipeline constants: widths, reset PC, bubble encoding and instruction field positions.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;

    localparam logic [PC_W-1:0]    RESET_PC = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP      = 16'h0000;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones, clears on reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc until all-ones; reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and
// saturating stall/flush event counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                   PC_W     = cpu_pkg::PC_W,
    parameter int                   INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]      RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0]   NOP      = cpu_pkg::NOP,
    parameter int                   CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_stall,
    input  logic                if_id_stall,
    input  logic                flush,
    input  logic [PC_W-1:0]     branch_target,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [PC_W-1:0]     if_id_pc_plus1,
    output logic                if_id_valid,
    output logic [REG_W-1:0]    if_id_rs,
    output logic [REG_W-1:0]    if_id_rt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_plus1;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_plus1;
    logic               r_valid;
    logic               w_stall_inc;

    // Increment wraps naturally at PC_W bits.
    assign w_pc_plus1 = r_pc + PC_W'(1);

    // PC update: redirect beats hold, hold beats sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (flush) begin
            r_pc <= branch_target;
        end else if (pc_stall) begin
            r_pc <= r_pc;
        end else begin
            r_pc <= w_pc_plus1;
        end
    end

    // IF/ID register: squash the wrong-path instruction on redirect, even when held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP;
            r_pc_plus1 <= {PC_W{1'b0}};
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_instr    <= NOP;
            r_pc_plus1 <= {PC_W{1'b0}};
            r_valid    <= 1'b0;
        end else if (if_id_stall) begin
            r_instr    <= r_instr;
            r_pc_plus1 <= r_pc_plus1;
            r_valid    <= r_valid;
        end else begin
            r_instr    <= imem_rdata;
            r_pc_plus1 <= w_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    // A hold only counts when a redirect is not overriding it.
    assign w_stall_inc = if_id_stall & ~flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus1 = r_pc_plus1;
    assign if_id_valid    = r_valid;
    assign if_id_rs       = r_instr[RS_MSB:RS_LSB];
    assign if_id_rt       = r_instr[RT_MSB:RT_LSB];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the five-stage pipeline: owns the program counter and the IF/ID pipeline register, and drives the instruction-memory address. It consumes the hazard unit's PCstall/IF_IDstall outputs and the EX-stage branch redirect. It feeds the decode stage and the hazard unit's readREG1/readREG2 inputs. It also keeps saturating stall/flush event counters for performance debug.

Parameters:
PC_W, 16, program counter width; word addressed, one instruction per address.
INSTR_W, 16, instruction width.
RESET_PC, 0, PC value loaded by reset.
NOP, 16'h0000, instruction inserted as a bubble.
CNT_W, 16, width of the event counters.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_stall  in  1  hold PC (from hazard unit PCstall)
if_id_stall  in  1  hold IF/ID register (from hazard unit IF_IDstall)
flush  in  1  branch/jump taken, resolved in EX
branch_target  in  PC_W  redirect address, valid when flush=1
imem_addr  out  PC_W  instruction-memory address, equal to the current PC
imem_rdata  in  INSTR_W  instruction at imem_addr; combinational read, same cycle
if_id_instr  out  INSTR_W  registered instruction presented to ID
if_id_pc_plus1  out  PC_W  registered PC+1 of that instruction
if_id_valid  out  1  1 = real instruction; 0 = bubble
if_id_rs  out  3  if_id_instr[11:9], to hazard unit readREG1
if_id_rt  out  3  if_id_instr[8:6], to hazard unit readREG2
stall_cnt  out  CNT_W  cycles in which the IF/ID hold took effect
flush_cnt  out  CNT_W  cycles in which flush took effect

Behaviour:
- Reset (rst=1 at the edge): pc=RESET_PC, if_id_instr=NOP, if_id_pc_plus1=0, if_id_valid=0, stall_cnt=0, flush_cnt=0. Reset overrides every other input. Reset asserted mid-stall or mid-flush discards all in-flight state.
- imem_addr = pc, combinationally. if_id_rs and if_id_rt are combinational slices of the registered instruction.
- PC update priority at each edge: flush > pc_stall > advance.
  - flush=1: pc <= branch_target.
  - else pc_stall=1: pc holds.
  - else: pc <= pc+1, truncated to PC_W bits. 16'hFFFF wraps to 0 with no flag.
- IF/ID update priority at each edge: flush > if_id_stall > load.
  - flush=1: instr<=NOP, pc_plus1<=0, valid<=0, even if if_id_stall=1. The wrong-path instruction is squashed.
  - else if_id_stall=1: all IF/ID fields hold, including valid.
  - else: instr<=imem_rdata, pc_plus1<=pc+1 (wrapped), valid<=1.
- pc_stall and if_id_stall are independent inputs.
  - pc_stall=1, if_id_stall=0: the same instruction reloads into IF/ID next cycle. This is legal and intended.
  - pc_stall=0, if_id_stall=1: the fetched instruction is dropped. This is legal, and the bench only checks the register rules above.
- Latency: an instruction at address A appears on if_id_instr one cycle after pc==A, provided there is no stall or flush at that edge.
- Counters saturate at all-ones and do not wrap.
  - stall_cnt increments when if_id_stall=1 and flush=0.
  - flush_cnt increments when flush=1.
  - Neither counter increments during reset.
- There are no combinational paths from inputs to the IF/ID outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP encoding, RESET_PC, PC_W, INSTR_W
  - instruction field positions (opcode [15:12], rs [11:9], rt [8:6], rd [5:3])
  - register-address width 3
- These constants are reused by decode and the hazard unit.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, inc; output count). It is instantiated twice, once for stall_cnt and once for flush_cnt.

Test Plan:
1. Reset, then 5 idle cycles with imem_rdata=16'h1000+addr -> imem_addr runs 0,1,2,3,4,5. if_id_instr runs 1000,1001,…, one cycle behind. valid=1 from the first post-reset edge. pc_plus1 = addr+1.
2. At pc=3, hold pc_stall=if_id_stall=1 for 2 cycles -> pc stays 3. IF/ID holds 16'h1002/pc_plus1=3. Fetch resumes 3,4 afterwards. stall_cnt=2.
3. At pc=6, pulse flush=1 with branch_target=16'h0040 and if_id_stall=1 together -> next cycle pc=16'h0040, if_id_instr=NOP, valid=0, flush_cnt=1, stall_cnt unchanged. Following cycle if_id_instr=imem_rdata at 0x40.
4. Force pc=16'hFFFF via flush target, then advance -> pc wraps to 0. IF/ID pc_plus1 = 0 for the 0xFFFF instruction.
5. Assert rst while pc_stall=1 and if_id_valid=1 -> next cycle pc=0, valid=0, instr=NOP, both counters 0.
6. Hold if_id_stall=1 for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt saturates at 15.
